rd_dma: RTL and testbench

Avalon-MM read DMA: software programs a base address and byte count over a CSR slave, starts a transfer, and the block reads the region from memory through an Avalon-MM master, emitting it as one Avalon-ST packet. It sits between the memory interconnect and a streaming consumer (e.g. a pattern-matching pipeline) and raises a completion interrupt.

---
 rtl/rd_dma_regs_pkg.sv | 14 +
 rtl/rd_dma_fifo.sv | 48 ++++
 rtl/rd_dma.sv | 197 +++++++++++++++++++
 tb/tb_rd_dma.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rd_dma_regs_pkg.sv
// rd_dma CSR word addresses and control-state encoding.
package rd_dma_regs_pkg;
  localparam int unsigned REG_BASE_ADDR = 0;
  localparam int unsigned REG_SIZE      = 1;
  localparam int unsigned REG_IRQ_EN    = 2;
  localparam int unsigned REG_RUN       = 3;
  localparam int unsigned REG_STATUS    = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } state_t;
endpackage

// File: rtl/rd_dma_fifo.sv
// Show-ahead read-data buffer for rd_dma.
// Head word is visible on rdata whenever empty is low.
module rd_dma_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     rd,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   used
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic             do_wr;
  logic             do_rd;

  assign empty = used == '0;
  assign do_wr = wr && (used != (AW+1)'(DEPTH));
  assign do_rd = rd && !empty;
  assign rdata = mem[rp];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp   <= '0;
      rp   <= '0;
      used <= '0;
    end else begin
      if (do_wr) wp <= wp + AW'(1);
      if (do_rd) rp <= rp + AW'(1);
      unique case ({do_wr, do_rd})
        2'b10:   used <= used + (AW+1)'(1);
        2'b01:   used <= used - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wp] <= wdata;
  end
endmodule

// File: rtl/rd_dma.sv
// Avalon-MM read DMA: reads a programmed region and emits it
// as one big-endian Avalon-ST packet, with a done interrupt.
module rd_dma
  import rd_dma_regs_pkg::*;
#(
  parameter int AMM_DMA_DATA_W = 64,
  parameter int AMM_DMA_ADDR_W = 32,
  parameter int AMM_CSR_DATA_W = 32,
  parameter int AMM_CSR_ADDR_W = 4,
  parameter int FIFO_DEPTH     = 16,
  localparam int EMPTY_W       = $clog2(AMM_DMA_DATA_W / 8)
) (
  input  logic                      clk_i,
  input  logic                      srst_i,
  input  logic [AMM_CSR_ADDR_W-1:0] amm_slave_csr_address_i,
  input  logic                      amm_slave_csr_read_i,
  input  logic                      amm_slave_csr_write_i,
  input  logic [AMM_CSR_DATA_W-1:0] amm_slave_csr_writedata_i,
  output logic [AMM_CSR_DATA_W-1:0] amm_slave_csr_readdata_o,
  output logic [AMM_DMA_ADDR_W-1:0] amm_dma_address_o,
  output logic                      amm_dma_read_o,
  input  logic                      amm_dma_waitreques_i,
  input  logic [AMM_DMA_DATA_W-1:0] amm_dma_readdata_i,
  input  logic                      amm_dma_readdata_valid_i,
  output logic                      ast_source_valid_o,
  input  logic                      ast_source_ready_i,
  output logic [AMM_DMA_DATA_W-1:0] ast_source_data_o,
  output logic [EMPTY_W-1:0]        ast_source_empty_o,
  output logic                      ast_source_startofpacket_o,
  output logic                      ast_source_endofpacket_o,
  output logic                      irq_o
);
  localparam int BYTES = AMM_DMA_DATA_W / 8;
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int DW    = AMM_CSR_DATA_W;

  state_t state;
  state_t state_nx;

  logic [DW-1:0]             base_q;
  logic [DW-1:0]             size_q;
  logic [DW-1:0]             left_q;
  logic [DW-1:0]             beats_q;
  logic [DW-1:0]             beat_q;
  logic [AMM_DMA_ADDR_W-1:0] addr_q;
  logic [EMPTY_W-1:0]        tail_empty_q;
  logic                      irq_en_q;
  logic                      done_q;
  logic [CW-1:0]             pend_q;
  logic [CW-1:0]             used;
  logic [AMM_DMA_DATA_W-1:0] swapped;
  logic [AMM_DMA_DATA_W-1:0] head;
  logic [DW:0]               words_wide;
  logic [DW-1:0]             words;

  logic sel_base, sel_size, sel_ien, sel_run, sel_stat;
  logic busy, start, rd_acc, push, pop, last, fifo_empty, credit;

  assign sel_base = amm_slave_csr_address_i == AMM_CSR_ADDR_W'(REG_BASE_ADDR);
  assign sel_size = amm_slave_csr_address_i == AMM_CSR_ADDR_W'(REG_SIZE);
  assign sel_ien  = amm_slave_csr_address_i == AMM_CSR_ADDR_W'(REG_IRQ_EN);
  assign sel_run  = amm_slave_csr_address_i == AMM_CSR_ADDR_W'(REG_RUN);
  assign sel_stat = amm_slave_csr_address_i == AMM_CSR_ADDR_W'(REG_STATUS);

  assign busy  = state != ST_IDLE;
  assign start = amm_slave_csr_write_i && sel_run
              && amm_slave_csr_writedata_i[0] && !busy;

  assign words_wide = {1'b0, size_q} + (DW+1)'(BYTES - 1);
  assign words      = DW'(words_wide >> EMPTY_W);

  // In-flight plus buffered words never exceed the buffer, so
  // every returned word has a slot and the FIFO cannot overflow.
  assign credit = ({1'b0, pend_q} + {1'b0, used})
                < (CW+1)'(FIFO_DEPTH);

  assign amm_dma_read_o    = (state == ST_RUN) && credit;
  assign amm_dma_address_o = addr_q;
  assign rd_acc = amm_dma_read_o && !amm_dma_waitreques_i;

  // Responses with nothing outstanding belong to an aborted run.
  assign push = amm_dma_readdata_valid_i && (pend_q != '0);

  for (genvar i = 0; i < BYTES; i++) begin : g_swap
    assign swapped[AMM_DMA_DATA_W-8*(i+1) +: 8] =
      amm_dma_readdata_i[8*i +: 8];
  end

  rd_dma_fifo #(
    .WIDTH (AMM_DMA_DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (srst_i),
    .wr    (push),
    .wdata (swapped),
    .rd    (pop),
    .rdata (head),
    .empty (fifo_empty),
    .used  (used)
  );

  assign last = beat_q == beats_q - DW'(1);
  assign pop  = ast_source_valid_o && ast_source_ready_i;

  assign ast_source_valid_o = !fifo_empty;
  assign ast_source_data_o  = ast_source_valid_o ? head : '0;
  assign ast_source_startofpacket_o =
    ast_source_valid_o && (beat_q == '0);
  assign ast_source_endofpacket_o = ast_source_valid_o && last;
  assign ast_source_empty_o =
    (ast_source_valid_o && last) ? tail_empty_q : '0;

  assign irq_o = done_q && irq_en_q;

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:  if (start && size_q != '0) state_nx = ST_RUN;
      ST_RUN:   if (rd_acc && left_q == DW'(1)) state_nx = ST_DRAIN;
      ST_DRAIN: if (pop && last) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      base_q   <= '0;
      size_q   <= '0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      if (amm_slave_csr_write_i) begin
        if (sel_base) base_q   <= amm_slave_csr_writedata_i;
        if (sel_size) size_q   <= amm_slave_csr_writedata_i;
        if (sel_ien)  irq_en_q <= amm_slave_csr_writedata_i[0];
      end
      if ((start && size_q == '0) || (pop && last))
        done_q <= 1'b1;
      else if (amm_slave_csr_write_i && sel_stat
               && amm_slave_csr_writedata_i[1])
        done_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      addr_q       <= '0;
      left_q       <= '0;
      beats_q      <= '0;
      beat_q       <= '0;
      tail_empty_q <= '0;
      pend_q       <= '0;
    end else begin
      if (start) begin
        addr_q <= AMM_DMA_ADDR_W'(base_q)
                & ~AMM_DMA_ADDR_W'(BYTES - 1);
        left_q       <= words;
        beats_q      <= words;
        beat_q       <= '0;
        tail_empty_q <= EMPTY_W'(0) - size_q[EMPTY_W-1:0];
      end else begin
        if (rd_acc) begin
          addr_q <= addr_q + AMM_DMA_ADDR_W'(BYTES);
          left_q <= left_q - DW'(1);
        end
        if (pop) beat_q <= beat_q + DW'(1);
      end
      unique case ({rd_acc, push})
        2'b10:   pend_q <= pend_q + CW'(1);
        2'b01:   pend_q <= pend_q - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      amm_slave_csr_readdata_o <= '0;
    end else if (amm_slave_csr_read_i) begin
      amm_slave_csr_readdata_o <= '0;
      unique case (1'b1)
        sel_base: amm_slave_csr_readdata_o    <= base_q;
        sel_size: amm_slave_csr_readdata_o    <= size_q;
        sel_ien:  amm_slave_csr_readdata_o[0] <= irq_en_q;
        sel_run:  amm_slave_csr_readdata_o[0] <= busy;
        sel_stat: amm_slave_csr_readdata_o[1:0] <= {done_q, busy};
        default:  ;
      endcase
    end
  end
endmodule

// File: tb/tb_rd_dma.sv
// Randomized bench for rd_dma: memory responder, stream sink
// and a packet-level reference built from base/size.
module tb_rd_dma;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  csr_addr;
  logic        csr_read;
  logic        csr_write;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic [31:0] addr;
  logic        read;
  logic        waitreq;
  logic [63:0] rdata;
  logic        rdv;
  logic        valid;
  logic        ready;
  logic [63:0] data;
  logic [2:0]  empty;
  logic        sop;
  logic        eop;
  logic        irq;
  logic [4:0]  ctl;

  always #5 clk = ~clk;

  rd_dma dut (
    .clk_i                      (clk),
    .srst_i                     (rst),
    .amm_slave_csr_address_i    (csr_addr),
    .amm_slave_csr_read_i       (csr_read),
    .amm_slave_csr_write_i      (csr_write),
    .amm_slave_csr_writedata_i  (csr_wdata),
    .amm_slave_csr_readdata_o   (csr_rdata),
    .amm_dma_address_o          (addr),
    .amm_dma_read_o             (read),
    .amm_dma_waitreques_i       (waitreq),
    .amm_dma_readdata_i         (rdata),
    .amm_dma_readdata_valid_i   (rdv),
    .ast_source_valid_o         (valid),
    .ast_source_ready_i         (ready),
    .ast_source_data_o          (data),
    .ast_source_empty_o         (empty),
    .ast_source_startofpacket_o (sop),
    .ast_source_endofpacket_o   (eop),
    .irq_o                      (irq)
  );

  assign ctl = {sop, eop, empty};

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24]
         ^ {a[2:0], a[7:3]} ^ 8'h5a;
  endfunction

  int lat_max = 0;
  int wait_pct = 0;
  int rdy_pct = 100;
  int rdy_low = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int pop_cnt = 0;

  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic [31:0] exp_addr[$];
  logic [63:0] exp_data[$];
  logic [4:0]  exp_ctl[$];

  logic        hold_v = 1'b0;
  logic [31:0] hold_a;
  logic        st_v = 1'b0;
  logic [63:0] st_d;
  logic [4:0]  st_c;

  // Reference packet: word-aligned reads, big-endian beats.
  task automatic plan(input logic [31:0] base, input logic [31:0] size);
    int n;
    int e;
    logic [31:0] a0;
    n  = int'((size + 32'd7) / 32'd8);
    e  = (8 - int'(size % 32'd8)) % 8;
    a0 = base & ~32'd7;
    for (int i = 0; i < n; i++) begin
      logic [63:0] w;
      logic [31:0] a;
      a = a0 + 32'(8 * i);
      for (int j = 0; j < 8; j++)
        w[63 - 8*j -: 8] = mem_byte(a + 32'(j));
      exp_addr.push_back(a);
      exp_data.push_back(w);
      exp_ctl.push_back({i == 0, i == n - 1,
                         (i == n - 1) ? 3'(e) : 3'd0});
    end
  endtask

  initial begin
    waitreq = 1'b0;
    rdv     = 1'b0;
    rdata   = '0;
    ready   = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_v = 1'b0;
        st_v   = 1'b0;
      end else begin
        if (hold_v) begin
          check("rd_hold", 64'(read), 64'd1);
          check("addr_hold", 64'(addr), 64'(hold_a));
        end
        hold_v = read && waitreq;
        hold_a = addr;
        if (read && !waitreq) begin
          acc_cnt++;
          pend_addr.push_back(addr);
          pend_due.push_back(cyc + 1 + int'($urandom_range(lat_max)));
          if (exp_addr.size() == 0) check("extra_read", 64'(addr), 64'hx);
          else check("rd_addr", 64'(addr), 64'(exp_addr.pop_front()));
        end
        if (st_v) begin
          check("st_hold_v", 64'(valid), 64'd1);
          check("st_hold_d", data, st_d);
          check("st_hold_c", 64'(ctl), 64'(st_c));
        end
        st_v = valid && !ready;
        st_d = data;
        st_c = ctl;
        if (valid && ready) begin
          pop_cnt++;
          if (exp_data.size() == 0) check("extra_beat", data, 64'hx);
          else begin
            check("beat_data", data, exp_data.pop_front());
            check("beat_ctl", 64'(ctl), 64'(exp_ctl.pop_front()));
          end
        end
      end
      @(posedge clk);
      #1;
      cyc++;
      waitreq = $urandom_range(99) < wait_pct;
      if (pend_addr.size() != 0 && pend_due[0] <= cyc) begin
        logic [31:0] a;
        a = pend_addr.pop_front();
        void'(pend_due.pop_front());
        rdv = 1'b1;
        for (int j = 0; j < 8; j++)
          rdata[8*j +: 8] = mem_byte(a + 32'(j));
      end else begin
        rdv   = 1'b0;
        rdata = {$urandom, $urandom};
      end
      if (rdy_low > 0) begin
        ready = 1'b0;
        rdy_low--;
      end else begin
        ready = $urandom_range(99) < rdy_pct;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_wr(input logic [3:0] a, input logic [31:0] d);
    csr_addr  = a;
    csr_wdata = d;
    csr_write = 1'b1;
    tick();
    csr_write = 1'b0;
  endtask

  task automatic csr_rd(input logic [3:0] a, output logic [31:0] d);
    csr_addr = a;
    csr_read = 1'b1;
    tick();
    csr_read = 1'b0;
    d = csr_rdata;
  endtask

  task automatic run_xfer(input logic [31:0] base, input logic [31:0] size,
                          input logic ien, input int rlow, input bit poke);
    logic [31:0] r;
    int n;
    plan(base, size);
    acc_cnt = 0;
    pop_cnt = 0;
    csr_wr(4'd0, base);
    csr_wr(4'd1, size);
    csr_wr(4'd2, {31'd0, ien});
    rdy_low = rlow;
    csr_wr(4'd3, 32'd1);
    check("read_t1", 64'(read), 64'(size != 0));
    if (rlow > 0) begin
      repeat (45) tick();
      check("credit_reads", 64'(acc_cnt), 64'd16);
      check("no_beats", 64'(pop_cnt), 64'd0);
    end
    if (poke) begin
      repeat (6) tick();
      csr_rd(4'd3, r);
      check("busy_rd", 64'(r), 64'd1);
      csr_wr(4'd1, 32'd999);
      csr_wr(4'd3, 32'd1);
      csr_rd(4'd1, r);
      check("size_wr_busy", 64'(r), 64'd999);
    end
    n = 0;
    while (exp_data.size() != 0 && n < 20000) begin
      tick();
      n++;
    end
    check("done_in_time", 64'(n < 20000), 64'd1);
    tick();
    csr_rd(4'd4, r);
    check("status_done", 64'(r), 64'd2);
    check("irq", 64'(irq), 64'(ien));
    check("reads_all", 64'(exp_addr.size()), 64'd0);
    csr_wr(4'd4, 32'd2);
    check("irq_clr", 64'(irq), 64'd0);
    csr_rd(4'd4, r);
    check("status_clr", 64'(r), 64'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    int n;
    rst       = 1'b1;
    csr_addr  = '0;
    csr_read  = 1'b0;
    csr_write = 1'b0;
    csr_wdata = '0;
    repeat (3) tick();
    check("rst_ctl", 64'({read, valid, sop, eop, irq, empty}), 64'd0);
    check("rst_addr", 64'(addr), 64'd0);
    check("rst_csr", 64'(csr_rdata), 64'd0);
    rst = 1'b0;
    tick();
    csr_rd(4'd4, r);
    check("status_rst", 64'(r), 64'd0);

    run_xfer(32'h1234_5678, 32'd34, 1'b1, 0, 1'b0);
    csr_rd(4'd0, r);
    check("base_rb", 64'(r), 64'h1234_5678);
    csr_rd(4'd1, r);
    check("size_rb", 64'(r), 64'd34);
    csr_rd(4'd2, r);
    check("ien_rb", 64'(r), 64'd1);
    csr_rd(4'd9, r);
    check("unmapped", 64'(r), 64'd0);

    run_xfer(32'h0000_1000, 32'd8, 1'b1, 0, 1'b0);
    run_xfer(32'h0000_2000, 32'd0, 1'b1, 0, 1'b0);

    wait_pct = 40;
    lat_max  = 3;
    run_xfer(32'h0000_3005, 32'd77, 1'b0, 0, 1'b0);

    wait_pct = 30;
    rdy_pct  = 100;
    run_xfer(32'h0000_4000, 32'd256, 1'b1, 60, 1'b0);

    rdy_pct = 40;
    run_xfer(32'h0000_8000, 32'd256, 1'b0, 0, 1'b1);

    repeat (6) begin
      wait_pct = int'($urandom_range(60));
      lat_max  = int'($urandom_range(5));
      rdy_pct  = 30 + int'($urandom_range(70));
      run_xfer($urandom, 32'($urandom_range(1, 200)),
               1'($urandom_range(1)), 0, 1'b0);
    end

    lat_max  = 4;
    wait_pct = 20;
    rdy_pct  = 50;
    plan(32'h0000_9000, 32'd256);
    csr_wr(4'd0, 32'h0000_9000);
    csr_wr(4'd1, 32'd256);
    csr_wr(4'd2, 32'd1);
    csr_wr(4'd3, 32'd1);
    repeat (20) tick();
    rst = 1'b1;
    #1;
    check("mid_rst_ctl", 64'({read, valid, sop, eop, irq, empty}), 64'd0);
    check("mid_rst_addr", 64'(addr), 64'd0);
    check("mid_rst_data", data, 64'd0);
    exp_addr.delete();
    exp_data.delete();
    exp_ctl.delete();
    repeat (2) tick();
    rst = 1'b0;
    n = 0;
    while (pend_addr.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    check("late_drain", 64'(n < 100), 64'd1);
    repeat (3) tick();
    check("post_rst_valid", 64'(valid), 64'd0);
    csr_rd(4'd4, r);
    check("post_rst_status", 64'(r), 64'd0);
    csr_rd(4'd0, r);
    check("post_rst_base", 64'(r), 64'd0);
    csr_rd(4'd2, r);
    check("post_rst_ien", 64'(r), 64'd0);
    run_xfer(32'h0000_a000, 32'd40, 1'b1, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
